// File: rtl/reducer_pkg.sv
// -----------------------------------------------------------------------------
// reducer_pkg
// Shared types and default configuration for the block reducer slice.
//   reducer_state_t : FSM state encoding (IDLE, REQ, COLLECT, HOLD)
//   DEF_*           : default parameter values used by the interface and modules
// -----------------------------------------------------------------------------
package reducer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } reducer_state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_LOGDEPTH    = 6;
  localparam int DEF_BLOCK_LEN   = 64;
  localparam int DEF_GAP_TIMEOUT = 16;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/block_reducer_if.sv
// -----------------------------------------------------------------------------
// block_reducer_if
// Groups the block reducer's request, data and result handshakes.
//   slave  modport : the reducer itself
//   master modport : the requester / product source / result consumer
// Signals:
//   EN_reduce, RDY_reduce         : block reduce request handshake
//   EN_blockRead                  : one-cycle upstream block read request
//   VALID_memVal, memVal_data     : incoming product words
//   VALID_result, result_*        : reduced block result
//   ACK_result                    : consumer accepts the result
// -----------------------------------------------------------------------------
interface block_reducer_if
  import reducer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOGDEPTH = DEF_LOGDEPTH
);

  logic                      EN_reduce;
  logic                      RDY_reduce;
  logic                      EN_blockRead;
  logic                      VALID_memVal;
  logic [WIDTH-1:0]          memVal_data;
  logic                      VALID_result;
  logic [WIDTH+LOGDEPTH-1:0] result_sum;
  logic [WIDTH-1:0]          result_max;
  logic [LOGDEPTH:0]         result_count;
  logic                      result_short;
  logic                      ACK_result;

  modport slave (
    input  EN_reduce,
    output RDY_reduce,
    output EN_blockRead,
    input  VALID_memVal,
    input  memVal_data,
    output VALID_result,
    output result_sum,
    output result_max,
    output result_count,
    output result_short,
    input  ACK_result
  );

  modport master (
    output EN_reduce,
    input  RDY_reduce,
    input  EN_blockRead,
    output VALID_memVal,
    output memVal_data,
    input  VALID_result,
    input  result_sum,
    input  result_max,
    input  result_count,
    input  result_short,
    output ACK_result
  );

endinterface

// File: rtl/reducer_gap_timer.sv
// -----------------------------------------------------------------------------
// reducer_gap_timer
// Counts consecutive idle cycles while a block is being collected.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count at zero (takes priority over tick)
//   tick     : one more idle cycle has elapsed
//   expired  : combinational; high on the tick that brings the count to
//              GAP_TIMEOUT, so the owner can leave on that same edge
// -----------------------------------------------------------------------------
module reducer_gap_timer
  import reducer_pkg::*;
#(
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = cnt_width(GAP_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(GAP_TIMEOUT - 1)) begin
        expired = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_reducer.sv
// -----------------------------------------------------------------------------
// block_reducer
// Requests one block from the upstream product buffer, then reduces the words
// that arrive into a sum, a maximum and a beat count. The block ends after
// BLOCK_LEN beats, or early when GAP_TIMEOUT consecutive idle cycles pass.
// The result is held until the consumer acknowledges it.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, discards any partial block
//   bus  : block_reducer_if.slave (request, data and result handshakes)
// Configuration:
//   BLOCK_REDUCER_MAX_EN defined   : maximum tracking compiled in
//   BLOCK_REDUCER_MAX_EN undefined : no comparator/register, result_max = 0
// -----------------------------------------------------------------------------
module block_reducer
  import reducer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LOGDEPTH    = DEF_LOGDEPTH,
  parameter int BLOCK_LEN   = DEF_BLOCK_LEN,
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  block_reducer_if.slave bus
);

  localparam int SUM_W = WIDTH + LOGDEPTH;
  // Count value held just before the final beat is accepted.
  localparam logic [LOGDEPTH:0] LAST_CNT = (LOGDEPTH + 1)'(BLOCK_LEN - 1);

  reducer_state_t     state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [LOGDEPTH:0]  count_q, count_d;
  logic               short_q, short_d;
`ifdef BLOCK_REDUCER_MAX_EN
  logic [WIDTH-1:0]   max_q, max_d;
`endif

  logic gap_clear;
  logic gap_tick;
  logic gap_expired;

  reducer_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .tick    (gap_tick),
    .expired (gap_expired)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    short_d   = short_q;
`ifdef BLOCK_REDUCER_MAX_EN
    max_d     = max_q;
`endif
    gap_clear = 1'b0;
    gap_tick  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.EN_reduce) begin
          state_d   = REQ;
          sum_d     = '0;
          count_d   = '0;
          short_d   = 1'b0;
`ifdef BLOCK_REDUCER_MAX_EN
          max_d     = '0;
`endif
          gap_clear = 1'b1;
        end
      end

      REQ: begin
        state_d = COLLECT;
      end

      COLLECT: begin
        if (bus.VALID_memVal) begin
          sum_d     = sum_q + {{LOGDEPTH{1'b0}}, bus.memVal_data};
          count_d   = count_q + 1'b1;
`ifdef BLOCK_REDUCER_MAX_EN
          if (bus.memVal_data > max_q) begin
            max_d = bus.memVal_data;
          end
`endif
          gap_clear = 1'b1;
          if (count_q == LAST_CNT) begin
            state_d = HOLD;
            short_d = 1'b0;
          end
        end else begin
          gap_tick = 1'b1;
          if (gap_expired) begin
            state_d = HOLD;
            short_d = 1'b1;
          end
        end
      end

      HOLD: begin
        // Fields are frozen here; only the acknowledge moves the FSM.
        if (bus.ACK_result) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      count_q <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      short_q <= short_d;
    end
  end

`ifdef BLOCK_REDUCER_MAX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign bus.result_max = max_q;
`else
  assign bus.result_max = '0;
`endif

  assign bus.RDY_reduce   = (state_q == IDLE);
  assign bus.EN_blockRead = (state_q == REQ);
  assign bus.VALID_result = (state_q == HOLD);
  assign bus.result_sum   = sum_q;
  assign bus.result_count = count_q;
  assign bus.result_short = short_q;

endmodule

// File: tb/tb_block_reducer.sv
module tb_block_reducer;
  import reducer_pkg::*;

  localparam int WIDTH       = 32;
  localparam int LOGDEPTH    = 6;
  localparam int BLOCK_LEN   = 64;
  localparam int GAP_TIMEOUT = 16;

`ifdef BLOCK_REDUCER_MAX_EN
  localparam bit MAX_ON = 1'b1;
`else
  localparam bit MAX_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  block_reducer_if #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) bus ();

  block_reducer #(
    .WIDTH       (WIDTH),
    .LOGDEPTH    (LOGDEPTH),
    .BLOCK_LEN   (BLOCK_LEN),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for request, 1 read request, 2 gathering, 3 result held
  int          m_phase = 0;
  logic [31:0] m_words[$];
  int          m_idle = 0;
  bit          m_short = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_words.delete();
      m_idle  = 0;
      m_short = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.EN_reduce) begin
             m_phase = 1;
             m_words.delete();
             m_idle  = 0;
             m_short = 1'b0;
           end
        1: m_phase = 2;
        2: if (bus.VALID_memVal) begin
             m_words.push_back(bus.memVal_data);
             m_idle = 0;
             if (m_words.size() == BLOCK_LEN) m_phase = 3;
           end else begin
             m_idle++;
             if (m_idle == GAP_TIMEOUT) begin
               m_phase = 3;
               m_short = 1'b1;
             end
           end
        default: if (bus.ACK_result) m_phase = 0;
      endcase
    end
  end

  function automatic logic [63:0] model_sum();
    logic [63:0] s = 0;
    foreach (m_words[i]) s += 64'(m_words[i]);
    return s;
  endfunction

  function automatic logic [63:0] model_max();
    logic [31:0] m = 0;
    foreach (m_words[i]) if (m_words[i] > m) m = m_words[i];
    return MAX_ON ? 64'(m) : 64'd0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_rdy",   64'(bus.RDY_reduce),   64'(m_phase == 0));
      chk("m_read",  64'(bus.EN_blockRead), 64'(m_phase == 1));
      chk("m_valid", 64'(bus.VALID_result), 64'(m_phase == 3));
      if (m_phase == 3) begin
        chk("m_sum",   64'(bus.result_sum),   model_sum());
        chk("m_max",   64'(bus.result_max),   model_max());
        chk("m_count", 64'(bus.result_count), 64'(m_words.size()));
        chk("m_short", 64'(bus.result_short), 64'(m_short));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_block();
    bus.EN_reduce = 1'b1;
    step(1);               // now in REQ
    bus.EN_reduce = 1'b0;
    step(1);               // now in COLLECT
  endtask

  task automatic beat(input logic [31:0] d);
    bus.VALID_memVal = 1'b1;
    bus.memVal_data  = d;
    step(1);
    bus.VALID_memVal = 1'b0;
    bus.memVal_data  = '0;
  endtask

  task automatic wait_hold(input string name, input int budget);
    for (int i = 0; i < budget && !bus.VALID_result; i++) step(1);
    chk(name, 64'(bus.VALID_result), 64'd1);
  endtask

  task automatic ack();
    bus.ACK_result = 1'b1;
    step(1);
    bus.ACK_result = 1'b0;
    chk("ack_idle", 64'(bus.RDY_reduce), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(bus.VALID_result), 64'd0);
    chk({tag, "_read"},  64'(bus.EN_blockRead), 64'd0);
    chk({tag, "_sum"},   64'(bus.result_sum),   64'd0);
    chk({tag, "_max"},   64'(bus.result_max),   64'd0);
    chk({tag, "_count"}, 64'(bus.result_count), 64'd0);
    chk({tag, "_short"}, 64'(bus.result_short), 64'd0);
    chk({tag, "_rdy"},   64'(bus.RDY_reduce),   64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst              = 1'b1;
    bus.EN_reduce    = 1'b0;
    bus.VALID_memVal = 1'b0;
    bus.memVal_data  = '0;
    bus.ACK_result   = 1'b0;
    step(3);
    rst = 1'b0;
    chk_reset_vals("reset");
    cmp_en = 1'b1;
    step(2);

    // 64 contiguous beats 1..64
    start_block();
    chk("req_pulse_gone", 64'(bus.EN_blockRead), 64'd0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) chk("pre_last_valid", 64'(bus.VALID_result), 64'd0);
      beat(32'(i));
    end
    chk("seq_latency1", 64'(bus.VALID_result), 64'd1);
    chk("seq_sum",   64'(bus.result_sum),   64'd2080);
    chk("seq_max",   64'(bus.result_max),   MAX_ON ? 64'd64 : 64'd0);
    chk("seq_count", 64'(bus.result_count), 64'd64);
    chk("seq_short", 64'(bus.result_short), 64'd0);
    ack();
    step(1);

    // 63 beats of all-ones then silence
    start_block();
    for (int i = 0; i < 63; i++) beat(32'hFFFF_FFFF);
    step(15);
    chk("gap15_not_done", 64'(bus.VALID_result), 64'd0);
    step(1);
    chk("gap16_done", 64'(bus.VALID_result), 64'd1);
    chk("ones_sum",   64'(bus.result_sum),   64'h3E_FFFF_FFC1);
    chk("ones_max",   64'(bus.result_max),   MAX_ON ? 64'hFFFF_FFFF : 64'd0);
    chk("ones_count", 64'(bus.result_count), 64'd63);
    chk("ones_short", 64'(bus.result_short), 64'd1);
    ack();

    // 64 beats of 5 with one idle cycle between
    start_block();
    for (int i = 0; i < 64; i++) begin
      beat(32'd5);
      if (i != 63) step(1);
    end
    wait_hold("gap5_hold", 4);
    chk("gap5_sum",   64'(bus.result_sum),   64'd320);
    chk("gap5_count", 64'(bus.result_count), 64'd64);
    chk("gap5_short", 64'(bus.result_short), 64'd0);

    // held result survives stray requests and data
    bus.EN_reduce    = 1'b1;
    bus.VALID_memVal = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.memVal_data = 32'(1000 + i);
      step(1);
    end
    bus.EN_reduce    = 1'b0;
    bus.VALID_memVal = 1'b0;
    chk("hold_valid", 64'(bus.VALID_result), 64'd1);
    chk("hold_sum",   64'(bus.result_sum),   64'd320);
    chk("hold_max",   64'(bus.result_max),   MAX_ON ? 64'd5 : 64'd0);
    chk("hold_count", 64'(bus.result_count), 64'd64);
    ack();

    // zero beats then timeout
    start_block();
    step(GAP_TIMEOUT);
    chk("empty_valid", 64'(bus.VALID_result), 64'd1);
    chk("empty_sum",   64'(bus.result_sum),   64'd0);
    chk("empty_count", 64'(bus.result_count), 64'd0);
    chk("empty_short", 64'(bus.result_short), 64'd1);
    ack();

    // reset in the middle of a block
    start_block();
    for (int i = 0; i < 10; i++) beat(32'd7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    start_block();
    for (int i = 0; i < 64; i++) beat(32'd1);
    chk("after_rst_valid", 64'(bus.VALID_result), 64'd1);
    chk("after_rst_sum",   64'(bus.result_sum),   64'd64);
    chk("after_rst_count", 64'(bus.result_count), 64'd64);
    ack();
    step(2);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_reducer.md
BLOCK_REDUCER -- requirements
Module: block_reducer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter LOGDEPTH, default 6, SHALL set log2 of the memory block depth.
REQ-003 Parameter BLOCK_LEN, default 64, SHALL set expected beats per block (1..2**LOGDEPTH).
REQ-004 Parameter GAP_TIMEOUT, default 16, SHALL set consecutive idle cycles that end a block early.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 EN_reduce  in  1  request to reduce one block.
REQ-008 RDY_reduce  out  1  high when the block can accept EN_reduce.
REQ-009 EN_blockRead  out  1  one-cycle pulse requesting a block read from the upstream product buffer.
REQ-010 VALID_memVal  in  1  qualifies memVal_data.
REQ-011 memVal_data  in  WIDTH  unsigned product word.
REQ-012 VALID_result  out  1  result fields valid.
REQ-013 result_sum  out  WIDTH+LOGDEPTH  sum of accepted words.
REQ-014 result_max  out  WIDTH  maximum accepted word.
REQ-015 result_count  out  LOGDEPTH+1  number of accepted words.
REQ-016 result_short  out  1  block ended by timeout before BLOCK_LEN beats.
REQ-017 ACK_result  in  1  consumer accepts result.

Function
REQ-018 FSM SHALL have states IDLE, REQ, COLLECT, HOLD.
REQ-019 IDLE: RDY_reduce=1; EN_reduce=1 -> REQ next cycle, and sum/max/count/gap counter/short SHALL clear on that edge.
REQ-020 REQ: EN_blockRead=1 for exactly this one cycle, then COLLECT unconditionally.
REQ-021 EN_blockRead SHALL be 0 in every other state; RDY_reduce SHALL be 0 outside IDLE.
REQ-022 COLLECT, VALID_memVal=1: sum += zero-extended memVal_data (no wrap possible at widths given), count += 1, max = greater of max and data, gap counter cleared.
REQ-023 COLLECT, VALID_memVal=0: gap counter += 1; when it reaches GAP_TIMEOUT -> HOLD with short=1.
REQ-024 Beat making count equal BLOCK_LEN -> HOLD next cycle, short=0; VALID_result asserts the cycle after the final beat (latency 1).
REQ-025 Zero beats then timeout -> HOLD with sum=0, max=0, count=0, short=1.
REQ-026 HOLD: VALID_result=1, all result fields stable until handshake; ACK_result=1 -> IDLE next cycle.
REQ-027 VALID_memVal outside COLLECT, or after BLOCK_LEN beats, SHALL be ignored.
REQ-028 EN_reduce outside IDLE SHALL be ignored (not queued).
REQ-029 Result fields SHALL be driven from registers; VALID_result=0 outside HOLD.

Reset
REQ-030 rst SHALL force IDLE from any state, including mid-COLLECT, discarding the partial block.
REQ-031 Reset values: VALID_result=0, EN_blockRead=0, result_sum=0, result_max=0, result_count=0, result_short=0, RDY_reduce=1.

Configuration
REQ-032 Macro BLOCK_REDUCER_MAX_EN defined: max tracking per REQ-022 is compiled in.
REQ-033 Macro BLOCK_REDUCER_MAX_EN undefined: no comparator or max register; result_max SHALL be constant 0.

Structure
REQ-034 Package reducer_pkg SHALL hold enum reducer_state_t (IDLE, REQ, COLLECT, HOLD) and default parameter constants; the enum SHALL NOT be declared in compilation-unit scope.
REQ-035 Gap counter SHALL be a sub-module reducer_gap_timer (clear, tick, expired at GAP_TIMEOUT).

Verification
REQ-036 64 contiguous beats of values 1..64 -> sum=2080, max=64, count=64, short=0, VALID_result one cycle after beat 64.
REQ-037 63 beats of 0xFFFFFFFF then silence -> HOLD after 16 idle cycles, sum=0x3EFFFFFFC1, max=0xFFFFFFFF, count=63, short=1.
REQ-038 64 beats of 5 each separated by one idle cycle -> no timeout, sum=320, count=64, short=0.
REQ-039 ACK_result held low 10 cycles in HOLD with EN_reduce=1 and stray VALID_memVal beats -> result fields unchanged, state stays HOLD, then IDLE one cycle after ACK.
REQ-040 rst after 10 beats of 7 -> IDLE next cycle with outputs at reset values; following block of 64 beats of 1 gives sum=64.
REQ-041 Build without BLOCK_REDUCER_MAX_EN, repeat REQ-036 -> result_max=0, other fields identical.
